// File: rtl/interrupt_controller.sv
// Interrupt controller for the single-cycle CPU. It latches rising edges of the
// request lines and masks them. The lowest pending index is offered as a vector.
module interrupt_controller #(
  parameter int                    NUM_IRQ    = 8,
  parameter int                    ID_WIDTH   = 3,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 10'h3F0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    interrupcion,
  input  logic                  mask_we,
  input  logic [NUM_IRQ-1:0]    mask_wdata,
  input  logic                  int_ack,
  input  logic                  int_ret,
  output logic                  int_req,
  output logic [ADDR_WIDTH-1:0] int_vector,
  output logic [ID_WIDTH-1:0]   int_id,
  output logic [NUM_IRQ-1:0]    pending,
  output logic                  in_service,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_IRQ-1:0]  irq_prev;
  logic [NUM_IRQ-1:0]  mask;
  logic [NUM_IRQ-1:0]  edge_det;
  logic [NUM_IRQ-1:0]  active;
  logic [NUM_IRQ-1:0]  clr;
  logic [ID_WIDTH-1:0] winner;
  logic                any_active;
  logic                ack_take;
  logic                id_mask_off;

  assign fsm_state = state;

  always_comb begin
    edge_det   = interrupcion & ~irq_prev;
    active     = pending & mask;
    any_active = |active;
    ack_take   = (state == REQUEST) && int_ack;
  end

  // Lowest index wins: scanning downwards lets the lowest set bit overwrite.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) winner = ID_WIDTH'(i);
    end
  end

  // Decode the presented id into a clear vector and its pending mask write.
  always_comb begin
    clr         = '0;
    id_mask_off = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (int_id == ID_WIDTH'(i)) begin
        clr[i]      = ack_take;
        id_mask_off = mask_we & ~mask_wdata[i];
      end
    end
  end

  // A new edge ORs in after the clear, so a set coinciding with its clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev <= interrupcion;
      pending  <= '0;
      mask     <= '1;
    end else begin
      irq_prev <= interrupcion;
      pending  <= edge_det | (pending & ~clr);
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Handshake: int_req rises with int_id/int_vector and all three hold until
  // either int_ack is sampled high (transfer in that edge) or the presented
  // line is masked off (withdrawal). A sampled ack always beats withdrawal.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_id     <= '0;
      int_vector <= VEC_BASE;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_active) begin
            state      <= REQUEST;
            int_req    <= 1'b1;
            int_id     <= winner;
            int_vector <= VEC_BASE + ADDR_WIDTH'(winner);
          end
        end
        REQUEST: begin
          if (int_ack) begin
            state      <= SERVICE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
          end else if (id_mask_off) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (int_ret) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller. Each request the stimulus expects is
// queued as {id, vector}. A monitor pops an entry whenever int_req rises.
module tb_interrupt_controller;

  localparam int NUM_IRQ    = 8;
  localparam int ID_WIDTH   = 3;
  localparam int ADDR_WIDTH = 10;
  localparam int W          = ID_WIDTH + ADDR_WIDTH;

  logic                  clk;
  logic                  reset;
  logic [NUM_IRQ-1:0]    interrupcion;
  logic                  mask_we;
  logic [NUM_IRQ-1:0]    mask_wdata;
  logic                  int_ack;
  logic                  int_ret;
  logic                  int_req;
  logic [ADDR_WIDTH-1:0] int_vector;
  logic [ID_WIDTH-1:0]   int_id;
  logic [NUM_IRQ-1:0]    pending;
  logic                  in_service;
  logic [1:0]            fsm_state;

  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         req_q   = 1'b0;

  interrupt_controller dut (
    .clk          (clk),
    .reset        (reset),
    .interrupcion (interrupcion),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .int_ack      (int_ack),
    .int_ret      (int_ret),
    .int_req      (int_req),
    .int_vector   (int_vector),
    .int_id       (int_id),
    .pending      (pending),
    .in_service   (in_service),
    .fsm_state    (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising int_req must match the oldest queued {id, vector}.
  always @(negedge clk) begin
    if (int_req && !req_q) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got id %0d vector %0h, nothing queued", int_id, int_vector);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("req_id_vector", 32'({int_id, int_vector}), 32'(e));
      end
    end
    req_q = int_req;
  end

  // Driver tasks: inputs change at negedge, outputs are checked there as well.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_req(input int id);
    exp_q.push_back({ID_WIDTH'(id), ADDR_WIDTH'(10'h3F0 + id)});
  endtask

  task automatic pulse(input logic [NUM_IRQ-1:0] lines);
    interrupcion = lines;
    step(1);
    interrupcion = '0;
  endtask

  task automatic write_mask(input logic [NUM_IRQ-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    step(1);
    mask_we    = 1'b0;
  endtask

  task automatic serve();
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    int_ret = 1'b1;
    step(1);
    int_ret = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_int_req"}, 32'(int_req), 0);
    check({tag, "_int_id"}, 32'(int_id), 0);
    check({tag, "_int_vector"}, 32'(int_vector), 32'h3F0);
    check({tag, "_pending"}, 32'(pending), 0);
    check({tag, "_in_service"}, 32'(in_service), 0);
    check({tag, "_state"}, 32'(fsm_state), 0);
  endtask

  initial begin
    reset        = 1'b1;
    interrupcion = '0;
    mask_we      = 1'b0;
    mask_wdata   = '0;
    int_ack      = 1'b0;
    int_ret      = 1'b0;
    step(2);
    reset = 1'b0;
    check_reset_values("reset");

    // Three lines at once, served lowest index first.
    expect_req(0);
    pulse(8'b1001_0001);
    check("t1_pending", 32'(pending), 32'h91);
    check("t1_req_latency", 32'(int_req), 0);
    step(1);
    check("t1_req_up", 32'(int_req), 1);
    expect_req(4);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    check("t1_pending_after_ack", 32'(pending), 32'h90);
    check("t1_in_service", 32'(in_service), 1);
    check("t1_req_down", 32'(int_req), 0);
    check("t1_state_service", 32'(fsm_state), 2);
    int_ret = 1'b1;
    step(1);
    int_ret = 1'b0;
    check("t1_idle_gap", 32'(int_req), 0);
    check("t1_in_service_clr", 32'(in_service), 0);
    step(1);
    check("t1_id4_req", 32'(int_req), 1);
    expect_req(7);
    serve();
    step(1);
    serve();
    step(2);
    check("t1_drained_pending", 32'(pending), 0);
    check("t1_drained_req", 32'(int_req), 0);

    // Masked line stays pending until the mask is reopened.
    write_mask(8'hFE);
    pulse(8'h01);
    step(2);
    check("t3_masked_req", 32'(int_req), 0);
    check("t3_masked_pending", 32'(pending), 32'h01);
    expect_req(0);
    write_mask(8'hFF);
    check("t3_req_one_after_write", 32'(int_req), 0);
    step(1);
    check("t3_req_two_after_write", 32'(int_req), 1);
    serve();
    step(1);

    // Edges during service accumulate but are not presented until return.
    expect_req(2);
    pulse(8'h04);
    step(1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    pulse(8'b0101_0000);
    check("t4_pending", 32'(pending), 32'h50);
    check("t4_no_req", 32'(int_req), 0);
    check("t4_in_service", 32'(in_service), 1);
    step(1);
    check("t4_still_no_req", 32'(int_req), 0);
    expect_req(4);
    expect_req(6);
    int_ret = 1'b1;
    step(1);
    int_ret = 1'b0;
    step(1);
    serve();
    step(1);
    serve();
    step(1);

    // Withdraw by masking, then ack racing a fresh edge on the same line.
    expect_req(3);
    pulse(8'h08);
    step(1);
    write_mask(8'hF7);
    check("t5_withdrawn", 32'(int_req), 0);
    check("t5_still_pending", 32'(pending), 32'h08);
    check("t5_state_idle", 32'(fsm_state), 0);
    expect_req(3);
    write_mask(8'hFF);
    step(1);
    int_ack      = 1'b1;
    interrupcion = 8'h08;
    step(1);
    int_ack      = 1'b0;
    interrupcion = 8'h00;
    check("t5_set_wins_service", 32'(in_service), 1);
    check("t5_set_wins_pending", 32'(pending), 32'h08);
    expect_req(3);
    int_ret = 1'b1;
    step(1);
    int_ret = 1'b0;
    step(1);
    serve();
    step(1);

    // Ack and withdraw in the same cycle: ack wins.
    expect_req(1);
    pulse(8'h02);
    step(1);
    int_ack    = 1'b1;
    mask_we    = 1'b1;
    mask_wdata = 8'hFD;
    step(1);
    int_ack    = 1'b0;
    mask_we    = 1'b0;
    check("t5b_ack_wins", 32'(in_service), 1);
    check("t5b_pending", 32'(pending), 0);
    write_mask(8'hFF);
    int_ret = 1'b1;
    step(1);
    int_ret = 1'b0;
    step(1);

    // Reset in REQUEST with line 0 held high.
    expect_req(0);
    interrupcion = 8'h01;
    step(2);
    check("t6_req_before_reset", 32'(int_req), 1);
    reset = 1'b1;
    step(1);
    check_reset_values("t6_req_reset");
    reset = 1'b0;
    step(3);
    check("t6_no_req_after", 32'(int_req), 0);
    check("t6_no_pending_after", 32'(pending), 0);

    // Reset in SERVICE with line 0 held high.
    interrupcion = 8'h00;
    step(1);
    expect_req(0);
    interrupcion = 8'h01;
    step(2);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    check("t6_in_service_before_reset", 32'(in_service), 1);
    reset = 1'b1;
    step(1);
    check_reset_values("t6_svc_reset");
    reset = 1'b0;
    step(3);
    check("t6_svc_no_req_after", 32'(int_req), 0);
    check("t6_svc_no_pending_after", 32'(pending), 0);
    check("t6_svc_idle_after", 32'(in_service), 0);
    interrupcion = 8'h00;
    step(2);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Collects the external interrupt request lines of the single-cycle CPU (the 8-bit interrupt bus), latches rising edges into a pending register, masks and prioritises them, and presents one vector at a time to the CPU control unit through a req/ack handshake. It tracks the in-service interrupt until the CPU signals return-from-interrupt. There is no nesting. It sits between the top-level interrupt input and the CPU control/PC-select logic.

Parameters:
NUM_IRQ, 8, number of request lines
ID_WIDTH, 3, width of interrupt index; NUM_IRQ <= 2**ID_WIDTH
ADDR_WIDTH, 10, width of program-memory address (PC)
VEC_BASE, 10'h3F0, vector address of line 0; line i vectors to VEC_BASE+i (mod 2**ADDR_WIDTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
interrupcion  in  NUM_IRQ  request lines, sampled on clk rising edge
mask_we  in  1  write enable for mask register
mask_wdata  in  NUM_IRQ  new mask (1 = enabled)
int_ack  in  1  CPU has taken the vector this cycle
int_ret  in  1  CPU executed return-from-interrupt this cycle
int_req  out  1  interrupt presented to CPU
int_vector  out  ADDR_WIDTH  target address, valid while int_req=1
int_id  out  ID_WIDTH  index of presented/in-service line
pending  out  NUM_IRQ  pending register (visibility)
in_service  out  1  high while in SERVICE state

Behaviour:
- Reset (synchronous, sampled on the clk edge): pending=0, mask=all ones, state=IDLE, int_req=0, int_id=0, int_vector=VEC_BASE, in_service=0, irq_prev<=interrupcion. A line that is held high through reset does not raise an edge. Reset asserted in any state aborts the operation in one edge.
- Edge detect: edge[i] = interrupcion[i] & ~irq_prev[i]; irq_prev<=interrupcion every edge. Pulses that contain no rising clk edge are not captured.
- Pending update per edge: pending[i] <= edge[i] | (pending[i] & ~clr[i]). clr[i] is asserted only on an accepted int_ack for id i. If the set and the clear for the same bit happen in the same cycle, the set wins.
- Mask: written on mask_we. It gates arbitration only. Masked bits stay pending.
- Priority: among pending&mask, the lowest index wins.
- FSM (all outputs registered):
  - IDLE: if (pending&mask)!=0, go to REQUEST. Latch int_id=winner, int_vector=VEC_BASE+winner, int_req<=1.
  - REQUEST: hold int_req, int_id and int_vector stable.
    - On int_ack: clear pending[int_id], go to SERVICE, int_req<=0, in_service<=1.
    - Otherwise, if the mask bit of int_id is written to 0 (mask_we & ~mask_wdata[int_id]): withdraw, int_req<=0, go to IDLE. Ack has priority over withdraw in the same cycle.
    - A higher-priority arrival does not preempt a presented request.
  - SERVICE: no request is presented. Edges still accumulate in pending. On int_ret: in_service<=0, go to IDLE.
- int_ack outside REQUEST is ignored. int_ret outside SERVICE is ignored.
- Latency: a line sampled high at edge k (previously low) sets pending after edge k. int_req is high after edge k+1. After int_ret at edge r, the next request is high after edge r+1 (IDLE for one cycle).
- Back-to-back: the handshake completes in the same edge that samples int_ack=1. The earliest ack is one cycle after int_req rises.

Test Plan:
- Reset, then pulse interrupcion=8'b10010001 over one rising edge → pending=8'h91. One edge later: int_req=1, int_id=0, int_vector=10'h3F0.
- From the previous state, int_ack for one cycle → pending=8'h90, in_service=1, int_req=0. int_ret for one cycle → IDLE. Next edge: int_req=1, int_id=4, int_vector=10'h3F4. Repeat for id 7 → 10'h3F7.
- mask=8'hFE, pulse line 0 → no int_req, pending=8'h01. Write mask=8'hFF → int_req with id 0 two edges after the mask write.
- During SERVICE, pulse 8'b01010000 → pending=8'h50, int_req stays 0. After int_ret, id 4 is presented, then id 6.
- In REQUEST with id 3, clear mask bit 3 → int_req=0 next edge, pending[3] still 1. With int_ack and a new edge on line 3 in the same cycle → in SERVICE with pending[3]=1.
- Assert reset in REQUEST and again in SERVICE with interrupcion held at 8'h01 → all outputs return to reset values, and after reset is released no request is raised.
